// File: rtl/msg_schedule_ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha_sched_pkg
//  Description : Shared types, constants and sigma helpers for the SHA-2
//                message-schedule ring (SHA-256 and SHA-512 variants).
//  Revision    : 1.0  initial release
// ============================================================================
package sha_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DRAIN  = 2'd3
    } sched_state_e;

    localparam int RING_DEPTH = 16;

    // SHA-256 rotate / shift amounts
    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_SH = 10;

    // SHA-512 rotate / shift amounts
    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_SH = 6;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] sigma0_32(input logic [31:0] x);
        return rotr32(x, S256_S0_R1) ^ rotr32(x, S256_S0_R2) ^ (x >> S256_S0_SH);
    endfunction

    function automatic logic [31:0] sigma1_32(input logic [31:0] x);
        return rotr32(x, S256_S1_R1) ^ rotr32(x, S256_S1_R2) ^ (x >> S256_S1_SH);
    endfunction

    function automatic logic [63:0] sigma0_64(input logic [63:0] x);
        return rotr64(x, S512_S0_R1) ^ rotr64(x, S512_S0_R2) ^ (x >> S512_S0_SH);
    endfunction

    function automatic logic [63:0] sigma1_64(input logic [63:0] x);
        return rotr64(x, S512_S1_R1) ^ rotr64(x, S512_S1_R2) ^ (x >> S512_S1_SH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_schedule_ring_sigma.sv
`default_nettype none
// ============================================================================
//  Module      : sched_sigma
//  Description : Combinational small-sigma pair. sig0_o = sigma0(a_i),
//                sig1_o = sigma1(b_i); the function set follows WORD_W.
//  Revision    : 1.0  initial release
// ============================================================================
module sched_sigma
    import sha_sched_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [WORD_W-1:0] sig0_o,
    output logic [WORD_W-1:0] sig1_o
);

    generate
        if (WORD_W == 32) begin : g_sha256
            assign sig0_o = sigma0_32(a_i);
            assign sig1_o = sigma1_32(b_i);
        end else if (WORD_W == 64) begin : g_sha512
            assign sig0_o = sigma0_64(a_i);
            assign sig1_o = sigma1_64(b_i);
        end else begin : g_bad_width
            $error("sched_sigma: WORD_W must be 32 or 64");
            assign sig0_o = '0;
            assign sig1_o = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/msg_schedule_ring.sv
`default_nettype none
// ============================================================================
//  Module      : msg_schedule_ring
//  Description : SHA-2 message-schedule generator. Loads 16 message words,
//                expands them in place in a 16-entry ring and streams
//                W_0..W_(ROUNDS-1) over a valid/ready output.
//  Revision    : 1.0  initial release
// ============================================================================
module msg_schedule_ring
    import sha_sched_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int ROUNDS = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_word_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_word_o,
    output logic [6:0]        out_round_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
    localparam logic [6:0] LAST_LOAD  = 7'(RING_DEPTH - 1);

    generate
        if (ROUNDS < 17 || ROUNDS > 127) begin : g_bad_rounds
            $error("msg_schedule_ring: ROUNDS must be in 17..127");
        end
    endgenerate

    sched_state_e      state_q;
    logic [6:0]        t_q;
    logic [WORD_W-1:0] ring_q [RING_DEPTH];
    logic              out_valid_q;
    logic [WORD_W-1:0] out_word_q;
    logic [6:0]        out_round_q;
    logic              done_q;

    logic              out_free;
    logic [3:0]        idx_m2;
    logic [3:0]        idx_m7;
    logic [3:0]        idx_m15;
    logic [3:0]        idx_m16;
    logic [WORD_W-1:0] sig0;
    logic [WORD_W-1:0] sig1;
    logic [WORD_W-1:0] wt_d;

    // The output register can take a new word when empty or being drained.
    assign out_free   = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == ST_LOAD) && out_free;

    // Ring taps: mod-16 wrap of the 4-bit index gives the circular addressing.
    // The t-16 slot is the same slot W_t is written into.
    assign idx_m2  = t_q[3:0] - 4'd2;
    assign idx_m7  = t_q[3:0] - 4'd7;
    assign idx_m15 = t_q[3:0] - 4'd15;
    assign idx_m16 = t_q[3:0];

    sched_sigma #(
        .WORD_W (WORD_W)
    ) u_sigma (
        .a_i    (ring_q[idx_m15]),
        .b_i    (ring_q[idx_m2]),
        .sig0_o (sig0),
        .sig1_o (sig1)
    );

    assign wt_d = sig1 + ring_q[idx_m7] + sig0 + ring_q[idx_m16];

    // Control FSM, ring storage and registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_round_q <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < RING_DEPTH; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (start_i && state_q != ST_IDLE) begin
                // Abort: drop any pending word and reload from scratch.
                out_valid_q <= 1'b0;
                t_q         <= '0;
                state_q     <= ST_LOAD;
            end else begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_q <= 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            t_q     <= '0;
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (in_valid_i && in_ready_o) begin
                            ring_q[t_q[3:0]] <= in_word_i;
                            out_word_q       <= in_word_i;
                            out_round_q      <= t_q;
                            out_valid_q      <= 1'b1;
                            t_q              <= t_q + 7'd1;
                            if (t_q == LAST_LOAD) begin
                                state_q <= ST_EXPAND;
                            end
                        end
                    end
                    ST_EXPAND: begin
                        if (out_free) begin
                            ring_q[t_q[3:0]] <= wt_d;
                            out_word_q       <= wt_d;
                            out_round_q      <= t_q;
                            out_valid_q      <= 1'b1;
                            t_q              <= t_q + 7'd1;
                            if (t_q == LAST_ROUND) begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (out_valid_q && out_ready_i) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_word_o  = out_word_q;
    assign out_round_o = out_round_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_schedule_ring.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_schedule_ring
//  Description : Self-checking bench for msg_schedule_ring, one SHA-512 and
//                one SHA-256 instance, checked against a plain-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msg_schedule_ring;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // SHA-512 instance signals
    logic        s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [63:0] s_in_word = '0;
    logic        s_in_ready, s_out_valid, s_busy, s_done;
    logic [63:0] s_out_word;
    logic [6:0]  s_out_round;

    // SHA-256 instance signals
    logic        h_start = 1'b0, h_in_valid = 1'b0, h_out_ready = 1'b0;
    logic [31:0] h_in_word = '0;
    logic        h_in_ready, h_out_valid, h_busy, h_done;
    logic [31:0] h_out_word;
    logic [6:0]  h_out_round;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt64 = 0, done_edge64 = 0, start_edge64 = 0;
    int done_cnt32 = 0, done_edge32 = 0;

    logic [63:0] gw64 [$];
    logic [6:0]  gr64 [$];
    logic [31:0] gw32 [$];
    logic [6:0]  gr32 [$];
    logic [63:0] exp_w [128];
    logic [63:0] msg [16];

    always #5 clk = ~clk;

    msg_schedule_ring #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
        .clk(clk), .reset(reset), .start_i(s_start),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_word_i(s_in_word),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .out_word_o(s_out_word), .out_round_o(s_out_round),
        .busy_o(s_busy), .done_o(s_done)
    );

    msg_schedule_ring #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
        .clk(clk), .reset(reset), .start_i(h_start),
        .in_valid_i(h_in_valid), .in_ready_o(h_in_ready), .in_word_i(h_in_word),
        .out_valid_o(h_out_valid), .out_ready_i(h_out_ready),
        .out_word_o(h_out_word), .out_round_o(h_out_round),
        .busy_o(h_busy), .done_o(h_done)
    );

    // Edge counter used to time done against start.
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: records every output handshake and done pulse.
    always @(negedge clk) begin
        if (!reset && s_out_valid && s_out_ready) begin
            gw64.push_back(s_out_word);
            gr64.push_back(s_out_round);
        end
        if (s_done) begin
            done_cnt64++;
            done_edge64 = cyc;
        end
        if (!reset && h_out_valid && h_out_ready) begin
            gw32.push_back(h_out_word);
            gr32.push_back(h_out_round);
        end
        if (h_done) begin
            done_cnt32++;
            done_edge32 = cyc;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [63:0] mask;
        mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & mask;
    endfunction

    task automatic build_model(input int w, input int rounds);
        logic [63:0] mask, s0, s1, a, b;
        mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 16; i++) exp_w[i] = msg[i] & mask;
        for (int i = 16; i < rounds; i++) begin
            a = exp_w[i-15];
            b = exp_w[i-2];
            if (w == 32) begin
                s0 = rotr(a, 7, 32) ^ rotr(a, 18, 32) ^ (a >> 3);
                s1 = rotr(b, 17, 32) ^ rotr(b, 19, 32) ^ (b >> 10);
            end else begin
                s0 = rotr(a, 1, 64) ^ rotr(a, 8, 64) ^ (a >> 7);
                s1 = rotr(b, 19, 64) ^ rotr(b, 61, 64) ^ (b >> 6);
            end
            exp_w[i] = (s1 + exp_w[i-7] + s0 + exp_w[i-16]) & mask;
        end
    endtask

    task automatic random_msg();
        for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    endtask

    // Drives one SHA-512 block: start, load msg[], expand. Optional input
    // bubbles, two 5-cycle output stalls (at rounds 3 and 20), and an early
    // stop once out_round reaches stop_round (>= 0).
    task automatic run64(input bit bubbles, input bit stalls, input int stop_round, output bit finished);
        int idx, stall_left;
        bit did3, did20;
        logic [63:0] hold_w;
        logic [6:0]  hold_r;
        idx = 0; stall_left = 0; did3 = 0; did20 = 0; hold_w = '0; hold_r = '0;
        finished = 0;
        s_out_ready = 1'b0; s_in_valid = 1'b0; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        start_edge64 = cyc;
        gw64.delete(); gr64.delete();
        for (int cy = 0; cy < 400 && !finished; cy++) begin
            if (stalls && stall_left == 0 && s_out_valid &&
                ((s_out_round == 7'd3 && !did3) || (s_out_round == 7'd20 && !did20))) begin
                if (s_out_round == 7'd3) did3 = 1; else did20 = 1;
                stall_left = 5; hold_w = s_out_word; hold_r = s_out_round;
            end
            s_out_ready = (stall_left == 0);
            if (idx < 16) begin
                s_in_valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
                s_in_word  = msg[idx];
            end else begin
                s_in_valid = ($urandom_range(0, 1) == 1);
                s_in_word  = {$urandom, $urandom};
            end
            #1;
            if (stall_left > 0) begin
                total++;
                if (s_in_ready !== 1'b0 || s_out_word !== hold_w || s_out_round !== hold_r) begin
                    bad++;
                    $display("FAIL stall_hold: in_ready=%0b word=%h round=%0d, required in_ready=0 word=%h round=%0d",
                             s_in_ready, s_out_word, s_out_round, hold_w, hold_r);
                end
                stall_left--;
            end
            if (bubbles) begin
                total++;
                if (idx < 16 && s_out_valid && s_out_round >= 7'd16) begin
                    bad++;
                    $display("FAIL early_expand: round %0d seen after only %0d loaded words, required < 16", s_out_round, idx);
                end
            end
            if (idx < 16 && s_in_valid && s_in_ready) idx++;
            if (stop_round >= 0 && s_out_valid && s_out_round == 7'(stop_round)) begin
                finished = 1;
                break;
            end
            @(posedge clk); #1;
            if (s_done) finished = 1;
        end
        if (stop_round < 0) begin
            s_in_valid = 1'b0;
            s_out_ready = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst64_out_valid: got %b need 0", s_out_valid); end
        total++; if (s_out_word !== 64'd0) begin bad++; $display("FAIL rst64_out_word: got %h need 0", s_out_word); end
        total++; if (s_out_round !== 7'd0) begin bad++; $display("FAIL rst64_out_round: got %0d need 0", s_out_round); end
        total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL rst64_in_ready: got %b need 0", s_in_ready); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rst64_busy: got %b need 0", s_busy); end
        total++; if (s_done !== 1'b0) begin bad++; $display("FAIL rst64_done: got %b need 0", s_done); end
        total++; if (h_out_valid !== 1'b0) begin bad++; $display("FAIL rst32_out_valid: got %b need 0", h_out_valid); end
        total++; if (h_out_word !== 32'd0) begin bad++; $display("FAIL rst32_out_word: got %h need 0", h_out_word); end
        total++; if (h_out_round !== 7'd0) begin bad++; $display("FAIL rst32_out_round: got %0d need 0", h_out_round); end
        total++; if (h_busy !== 1'b0) begin bad++; $display("FAIL rst32_busy: got %b need 0", h_busy); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sha256_abc();
        int idx, se, d0;
        bit fin;
        logic [63:0] tmp;
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[0] = 64'h61626380;
        msg[15] = 64'h18;
        build_model(32, 64);
        d0 = done_cnt32; idx = 0; fin = 0;
        h_out_ready = 1'b1; h_start = 1'b1;
        @(posedge clk); #1;
        h_start = 1'b0; se = cyc;
        gw32.delete(); gr32.delete();
        for (int cy = 0; cy < 300 && !fin; cy++) begin
            tmp = (idx < 16) ? msg[idx] : 64'd0;
            h_in_valid = (idx < 16);
            h_in_word = tmp[31:0];
            #1;
            if (h_in_valid && h_in_ready) idx++;
            @(posedge clk); #1;
            if (h_done) fin = 1;
        end
        h_in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (!fin) begin bad++; $display("FAIL sha256_timeout: done not seen in 300 cycles"); end
        total++; if (gw32.size() != 64) begin bad++; $display("FAIL sha256_count: got %0d words need 64", gw32.size()); end
        total++; if (gw32.size() > 17 && gw32[16] !== 32'h61626380) begin bad++; $display("FAIL sha256_W16: got %h need 61626380", gw32[16]); end
        total++; if (gw32.size() > 17 && gw32[17] !== 32'h000F0000) begin bad++; $display("FAIL sha256_W17: got %h need 000f0000", gw32[17]); end
        for (int i = 0; i < gw32.size() && i < 64; i++) begin
            total++;
            if (gw32[i] !== exp_w[i][31:0] || gr32[i] !== 7'(i)) begin
                bad++;
                $display("FAIL sha256_word[%0d]: got round %0d word %h need round %0d word %h", i, gr32[i], gw32[i], i, exp_w[i][31:0]);
            end
        end
        total++; if (done_cnt32 - d0 != 1) begin bad++; $display("FAIL sha256_done_count: got %0d need 1", done_cnt32 - d0); end
        total++; if (done_edge32 - se != 65) begin bad++; $display("FAIL sha256_done_edge: got %0d need 65", done_edge32 - se); end
    endtask

    task automatic test_sha512_abc();
        int d0;
        bit fin;
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[0] = 64'h6162638000000000;
        msg[15] = 64'h18;
        build_model(64, 80);
        d0 = done_cnt64;
        run64(1'b0, 1'b0, -1, fin);
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL sha512_done_pulse: got %b need 1", s_done); end
        @(posedge clk); #1;
        total++; if (s_done !== 1'b0) begin bad++; $display("FAIL sha512_done_width: got %b need 0", s_done); end
        total++; if (!fin) begin bad++; $display("FAIL sha512_timeout: done not seen in 400 cycles"); end
        total++; if (gw64.size() != 80) begin bad++; $display("FAIL sha512_count: got %0d words need 80", gw64.size()); end
        total++; if (gw64.size() > 17 && gw64[16] !== 64'h6162638000000000) begin bad++; $display("FAIL sha512_W16: got %h need 6162638000000000", gw64[16]); end
        total++; if (gw64.size() > 17 && gw64[17] !== 64'h00030000000000C0) begin bad++; $display("FAIL sha512_W17: got %h need 00030000000000c0", gw64[17]); end
        for (int i = 0; i < gw64.size() && i < 80; i++) begin
            total++;
            if (gw64[i] !== exp_w[i] || gr64[i] !== 7'(i)) begin
                bad++;
                $display("FAIL sha512_word[%0d]: got round %0d word %h need round %0d word %h", i, gr64[i], gw64[i], i, exp_w[i]);
            end
        end
        total++; if (done_cnt64 - d0 != 1) begin bad++; $display("FAIL sha512_done_count: got %0d need 1", done_cnt64 - d0); end
        total++; if (done_edge64 - start_edge64 != 81) begin bad++; $display("FAIL sha512_done_edge: got %0d need 81", done_edge64 - start_edge64); end
    endtask

    task automatic test_backpressure();
        bit fin;
        random_msg();
        build_model(64, 80);
        run64(1'b0, 1'b1, -1, fin);
        @(posedge clk); #1;
        total++; if (!fin) begin bad++; $display("FAIL bp_timeout: done not seen"); end
        total++; if (gw64.size() != 80) begin bad++; $display("FAIL bp_count: got %0d words need 80", gw64.size()); end
        for (int i = 0; i < gw64.size() && i < 80; i++) begin
            total++;
            if (gw64[i] !== exp_w[i] || gr64[i] !== 7'(i)) begin
                bad++;
                $display("FAIL bp_word[%0d]: got round %0d word %h need round %0d word %h", i, gr64[i], gw64[i], i, exp_w[i]);
            end
        end
    endtask

    task automatic test_input_bubbles();
        bit fin;
        random_msg();
        build_model(64, 80);
        run64(1'b1, 1'b0, -1, fin);
        @(posedge clk); #1;
        total++; if (!fin) begin bad++; $display("FAIL bubble_timeout: done not seen"); end
        total++; if (gw64.size() != 80) begin bad++; $display("FAIL bubble_count: got %0d words need 80", gw64.size()); end
        for (int i = 0; i < gw64.size() && i < 80; i++) begin
            total++;
            if (gw64[i] !== exp_w[i] || gr64[i] !== 7'(i)) begin
                bad++;
                $display("FAIL bubble_word[%0d]: got round %0d word %h need round %0d word %h", i, gr64[i], gw64[i], i, exp_w[i]);
            end
        end
    endtask

    task automatic test_abort();
        int d0;
        bit fin;
        d0 = done_cnt64;
        random_msg();
        run64(1'b0, 1'b0, 40, fin);
        total++; if (!fin) begin bad++; $display("FAIL abort_reach40: round 40 not reached"); end
        random_msg();
        build_model(64, 80);
        run64(1'b1, 1'b0, -1, fin);
        @(posedge clk); #1;
        total++; if (!fin) begin bad++; $display("FAIL abort_timeout: second block done not seen"); end
        total++; if (done_cnt64 - d0 != 1) begin bad++; $display("FAIL abort_done_count: got %0d need 1", done_cnt64 - d0); end
        total++; if (gr64.size() == 0 || gr64[0] !== 7'd0) begin bad++; $display("FAIL abort_restart_round: got %0d need 0", (gr64.size() == 0) ? -1 : int'(gr64[0])); end
        total++; if (gw64.size() != 80) begin bad++; $display("FAIL abort_count: got %0d words need 80", gw64.size()); end
        for (int i = 0; i < gw64.size() && i < 80; i++) begin
            total++;
            if (gw64[i] !== exp_w[i] || gr64[i] !== 7'(i)) begin
                bad++;
                $display("FAIL abort_word[%0d]: got round %0d word %h need round %0d word %h", i, gr64[i], gw64[i], i, exp_w[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        random_msg();
        run64(1'b0, 1'b0, 50, fin);
        total++; if (!fin) begin bad++; $display("FAIL rmid_reach50: round 50 not reached"); end
        reset = 1'b1;
        #1;
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b need 0", s_out_valid); end
        total++; if (s_out_word !== 64'd0) begin bad++; $display("FAIL rmid_out_word: got %h need 0", s_out_word); end
        total++; if (s_out_round !== 7'd0) begin bad++; $display("FAIL rmid_out_round: got %0d need 0", s_out_round); end
        total++; if (s_in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready: got %b need 0", s_in_ready); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b need 0", s_busy); end
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        random_msg();
        build_model(64, 80);
        run64(1'b0, 1'b0, -1, fin);
        @(posedge clk); #1;
        total++; if (!fin) begin bad++; $display("FAIL rmid_timeout: done not seen after reset"); end
        total++; if (gw64.size() != 80) begin bad++; $display("FAIL rmid_count: got %0d words need 80", gw64.size()); end
        for (int i = 0; i < gw64.size() && i < 80; i++) begin
            total++;
            if (gw64[i] !== exp_w[i] || gr64[i] !== 7'(i)) begin
                bad++;
                $display("FAIL rmid_word[%0d]: got round %0d word %h need round %0d word %h", i, gr64[i], gw64[i], i, exp_w[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sha256_abc();
        test_sha512_abc();
        test_backpressure();
        test_input_bubbles();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/msg_schedule_ring.md
# msg_schedule_ring

Parametrised SHA-2 message-schedule generator for the hash core. It accepts the 16 message words of one block over a valid/ready input, then expands them in place into the full round schedule W_0..W_(ROUNDS-1). It streams the words to the compression engine over a valid/ready output. Storage is a 16-entry circular buffer rather than a full-length word store, and the same RTL serves SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).

## Interface
- WORD_W, 64, word width. Only 32 (SHA-256 sigmas) or 64 (SHA-512 sigmas) is legal; any other value is an elaboration error.
- ROUNDS, 80, schedule length. Range 17..127; normally 64 or 80.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a new block
- in_valid  in  1  in_word is valid
- in_ready  out  1  block accepts in_word this cycle
- in_word  in  WORD_W  message word M_t, supplied in order t = 0..15
- out_valid  out  1  out_word/out_round hold a schedule word
- out_ready  in  1  consumer takes the word
- out_word  out  WORD_W  W_t
- out_round  out  7  t of out_word
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse after the last word is consumed

## Operation
- States: IDLE, LOAD, EXPAND, DRAIN. A 7-bit round counter t and a 16 x WORD_W ring hold the schedule.
- Reset: state IDLE, t=0, ring all zero, out_valid=0, out_word=0, out_round=0, in_ready=0, busy=0, done=0.
- IDLE: in_ready=0. On start: t←0, go to LOAD.
- Output stage is free when !out_valid || out_ready.
- LOAD:
  - in_ready = output stage free.
  - On in_valid && in_ready: ring[t[3:0]]←in_word, out_word←in_word, out_round←t, out_valid←1, t←t+1.
  - After t=15 is accepted, go to EXPAND.
- EXPAND: in_ready=0. Whenever the output stage is free:
  - Compute W_t = σ1(ring[(t-2)&15]) + ring[(t-7)&15] + σ0(ring[(t-15)&15]) + ring[(t-16)&15], mod 2^WORD_W.
  - ring[t&15]←W_t. This overwrites W_(t-16), which is read in the same cycle.
  - Load W_t into the output register and set t←t+1.
  - After t=ROUNDS-1 is produced, go to DRAIN.
- DRAIN: when out_valid && out_ready: out_valid←0, done←1 for one cycle, go to IDLE.
- Sigma functions:
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
- Abort: start while busy restarts the block.
  - out_valid←0, t←0, go to LOAD. Any pending output word is discarded.
  - done is not pulsed.
  - Ring contents are not cleared; they are overwritten by the new load.
- Holding rules:
  - in_valid while in_ready=0 is ignored, not buffered.
  - While out_valid && !out_ready, out_word and out_round hold stable and t does not advance.

## Timing
- Latency: accepted input word, or expansion step, at edge k → out_valid at edge k. The word is visible in the cycle after the edge.
- Throughput: 1 word per cycle with in_valid=1 and out_ready=1 held.
- Full-rate sequence:
  - start sampled at edge 0.
  - Words accepted at edges 1..16.
  - Expansion at edges 17..ROUNDS.
  - Final handshake at edge ROUNDS+1; done high in the cycle after edge ROUNDS+1.
- Combinational paths: the output handshake has no combinational path from out_ready to out_valid. in_ready depends combinationally on out_ready.
- Critical path: 4-operand WORD_W adder plus sigma XOR, one cycle.

## Structure
- Package sha_sched_pkg contains:
  - State enum.
  - ROTR/SHR amount constants for both widths.
  - Functions sigma0_32, sigma1_32, sigma0_64, sigma1_64.
  - RING_DEPTH=16.
- One sub-module, sched_sigma: parametrised on WORD_W, combinational, outputs σ0(a) and σ1(b). It is instantiated once in msg_schedule_ring.

## Test plan
- SHA-256 "abc":
  - Stimulus: WORD_W=32, ROUNDS=64; load W0=0x61626380, W1..W14=0, W15=0x00000018; out_ready=1.
  - Required: W16=0x61626380, W17=0x000F0000, 64 words with out_round 0..63, done once at the expected edge.
- SHA-512 "abc":
  - Stimulus: WORD_W=64, ROUNDS=80; W0=0x6162638000000000, W15=0x18, rest 0.
  - Required: W16=0x6162638000000000, W17=0x00030000000000C0, 80 words total; full schedule matches a reference model.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles at t=3 (LOAD) and at t=20 (EXPAND).
  - Required: in_ready=0 and out_word/out_round stable during the stall; no words lost or duplicated.
- Input bubbles:
  - Stimulus: in_valid toggled randomly during LOAD.
  - Required: exactly 16 words accepted in order; EXPAND is entered only after the 16th.
- Abort:
  - Stimulus: start at t=40, then a fresh block.
  - Required: no done for the first block; out_round restarts at 0; the second schedule is correct.
- Reset mid-EXPAND:
  - Stimulus: reset asserted at t=50.
  - Required: all outputs at reset values immediately; the next start/load yields a correct schedule.
